bsg_hash_bank_dispatch: RTL

BSG_HASH_BANK_DISPATCH -- requirements
Module: bsg_hash_bank_dispatch

---
 rtl/bsg_hash_bank_dispatch_if.sv | 27 ++
 rtl/bsg_hash_bank_dispatch.sv | 105 ++++++++++
 2 files changed

// File: rtl/bsg_hash_bank_dispatch_if.sv
// Request/response bundle for bsg_hash_bank_dispatch: one request port in,
// two per-bank FIFO heads out.
interface bsg_hash_bank_dispatch_if #(
  parameter int width_p       = 128,
  parameter int data_width_p  = 32,
  parameter int index_width_p = 2
);
  logic                                v_i;
  logic [width_p-1:0]                  addr_i;
  logic [data_width_p-1:0]             data_i;
  logic                                ready_o;
  logic [1:0]                          v_o;
  logic [1:0][index_width_p-1:0]       index_o;
  logic [1:0][data_width_p-1:0]        data_o;
  logic [1:0]                          yumi_i;
  logic [1:0][1:0]                     count_o;

  modport master (
    output v_i, addr_i, data_i, yumi_i,
    input  ready_o, v_o, index_o, data_o, count_o
  );

  modport slave (
    input  v_i, addr_i, data_i, yumi_i,
    output ready_o, v_o, index_o, data_o, count_o
  );
endinterface

// File: rtl/bsg_hash_bank_dispatch.sv
// Routes each request by address MSB into one of two independent 2-entry
// FIFOs holding {index, data}; no bypass, so accepted data appears next cycle.
module bsg_hash_bank_dispatch_chk (
  input logic       clk_i,
  input logic       reset_n_i,
  input logic [1:0] yumi_i,
  input logic [1:0] v_o
);
  // Consuming from an empty bank is a protocol violation; the RTL ignores it.
  a_yumi_on_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (yumi_i & ~v_o) == 2'b00)
    else $warning("illegal yumi_i on empty bank, yumi_i=%b v_o=%b", yumi_i, v_o);
endmodule

module bsg_hash_bank_dispatch #(
  parameter int width_p       = 128,
  parameter int data_width_p  = 32,
  parameter int index_width_p = 2,
  parameter int banks_p       = 2
) (
  input logic                    clk_i,
  input logic                    reset_n_i,
  bsg_hash_bank_dispatch_if.slave bus
);
  localparam int EntryW = index_width_p + data_width_p;

  if (banks_p != 2) begin : g_bad_banks
    $error("bsg_hash_bank_dispatch supports only banks_p == 2");
  end

  logic [1:0][1:0]             r_count;
  logic [1:0]                  r_rptr;
  logic [1:0]                  r_wptr;
  logic [1:0][1:0][EntryW-1:0] r_mem;

  logic       w_bank;
  logic       w_ready;
  logic [1:0] w_enq;
  logic [1:0] w_deq;
  logic       w_unused_addr;

  assign w_unused_addr = ^bus.addr_i;

  // Accept decision depends only on the target bank's occupancy, not on v_i.
  always_comb begin
    w_bank  = bus.addr_i[width_p-1];
    w_ready = (r_count[w_bank] != 2'd2);
    w_enq   = 2'b00;
    w_deq   = 2'b00;
    if (bus.v_i && w_ready) begin
      w_enq[w_bank] = 1'b1;
    end else begin
      w_enq = 2'b00;
    end
    // An empty bank ignores yumi so illegal strobes cannot corrupt pointers.
    for (int b = 0; b < 2; b++) begin
      w_deq[b] = bus.yumi_i[b] && (r_count[b] != 2'd0);
    end
  end

  // Head presentation straight from storage at the read pointer.
  always_comb begin
    bus.ready_o = w_ready;
    bus.count_o = r_count;
    for (int b = 0; b < 2; b++) begin
      bus.v_o[b]                   = (r_count[b] != 2'd0);
      {bus.index_o[b], bus.data_o[b]} = r_mem[b][r_rptr[b]];
    end
  end

  // Pointer and occupancy state; cleared asynchronously.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
      r_rptr  <= 2'b00;
      r_wptr  <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_enq[b]) begin
          r_wptr[b] <= ~r_wptr[b];
        end
        if (w_deq[b]) begin
          r_rptr[b] <= ~r_rptr[b];
        end
        r_count[b] <= r_count[b] + {1'b0, w_enq[b]} - {1'b0, w_deq[b]};
      end
    end
  end

  // FIFO storage has no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 2; b++) begin
      if (w_enq[b]) begin
        r_mem[b][r_wptr[b]] <= {bus.addr_i[index_width_p-1:0], bus.data_i};
      end
    end
  end

  bsg_hash_bank_dispatch_chk u_chk (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .yumi_i   (bus.yumi_i),
    .v_o      (bus.v_o)
  );
endmodule
